// File: rtl/ps2_car_keys_pkg.sv
// Scancode constants, receiver state encoding and parity helper shared by
// the PS/2 receiver and the car-key decoder.
package ps2_car_keys_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_PAUSE = 8'h4D;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_car_keys_rx.sv
// PS/2 frame receiver: synchronizers, clock glitch filter, falling-edge
// detect, start/data/parity/stop FSM and mid-frame timeout.
module ps2_rx
  import ps2_car_keys_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    clk_sync_r;
  logic [2:0]    data_sync_r;
  logic [FW-1:0] filt_cnt_r;
  logic          filt_r;
  logic          filt_prev_r;
  rx_state_e     state_r;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          parity_r;
  logic [TW-1:0] to_cnt_r;
  logic          fall_s;
  logic          data_s;
  logic          timeout_s;
  logic          stop_ok_s;

  // Synchronize both lines; the clock level only flips after FILTER_LEN agreeing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_r  <= 3'b111;
      data_sync_r <= 3'b111;
      filt_cnt_r  <= {FW{1'b0}};
      filt_r      <= 1'b1;
      filt_prev_r <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[1:0], ps2_clk};
      data_sync_r <= {data_sync_r[1:0], ps2_data};
      filt_prev_r <= filt_r;
      if (clk_sync_r[2] == filt_r) begin
        filt_cnt_r <= {FW{1'b0}};
      end else if (filt_cnt_r == FILT_MAX) begin
        filt_r     <= clk_sync_r[2];
        filt_cnt_r <= {FW{1'b0}};
      end else begin
        filt_cnt_r <= filt_cnt_r + FW'(1);
      end
    end
  end

  // Edge, timeout and stop-bit decisions feeding the FSM and the decoder
  always_comb begin
    data_s    = data_sync_r[2];
    fall_s    = filt_prev_r & ~filt_r;
    timeout_s = (state_r != ST_IDLE) && !fall_s && (to_cnt_r == TO_MAX);
    stop_ok_s = data_s && odd_parity_ok(shift_r, parity_r);
    rx_valid  = (state_r == ST_STOP) && fall_s && stop_ok_s;
    rx_err    = ((state_r == ST_STOP) && fall_s && !stop_ok_s) || timeout_s;
  end

  assign rx_byte = shift_r;

  // Frame FSM; the idle timer runs only mid-frame and restarts on every edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      parity_r  <= 1'b0;
      to_cnt_r  <= {TW{1'b0}};
    end else if ((state_r != ST_IDLE) && !fall_s) begin
      if (timeout_s) begin
        state_r  <= ST_IDLE;
        to_cnt_r <= {TW{1'b0}};
      end else begin
        to_cnt_r <= to_cnt_r + TW'(1);
      end
    end else begin
      to_cnt_r <= {TW{1'b0}};
      case (state_r)
        ST_IDLE: begin
          if (fall_s && !data_s) begin
            state_r   <= ST_DATA;
            bit_cnt_r <= 3'd0;
          end
        end
        ST_DATA: begin
          shift_r <= {data_s, shift_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            state_r <= ST_PARITY;
          end else begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
          end
        end
        ST_PARITY: begin
          parity_r <= data_s;
          state_r  <= ST_STOP;
        end
        ST_STOP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/ps2_car_keys.sv
// PS/2 keyboard front end for the car stage: decodes E0/F0 prefixes into held
// arrow-key levels and a debounced pause toggle.
module ps2_car_keys
  import ps2_car_keys_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       left_key,
  output logic       right_key,
  output logic       pause,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  logic       rx_valid_s;
  logic [7:0] rx_byte_s;
  logic       rx_err_s;
  logic       ext_r;
  logic       brk_r;
  logic       p_held_r;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_valid(rx_valid_s),
    .rx_byte (rx_byte_s),
    .rx_err  (rx_err_s)
  );

  // Prefix tracking and key-state decode; errors drop pending prefixes but keep key levels
  always_ff @(posedge clk) begin
    if (reset) begin
      left_key   <= 1'b0;
      right_key  <= 1'b0;
      pause      <= 1'b0;
      scan_valid <= 1'b0;
      scan_code  <= 8'h00;
      frame_err  <= 1'b0;
      ext_r      <= 1'b0;
      brk_r      <= 1'b0;
      p_held_r   <= 1'b0;
    end else begin
      scan_valid <= rx_valid_s;
      frame_err  <= rx_err_s;
      if (rx_err_s) begin
        ext_r <= 1'b0;
        brk_r <= 1'b0;
      end else if (rx_valid_s) begin
        scan_code <= rx_byte_s;
        case (rx_byte_s)
          SC_EXT:   ext_r <= 1'b1;
          SC_BREAK: brk_r <= 1'b1;
          default: begin
            if (ext_r && (rx_byte_s == SC_LEFT)) begin
              left_key <= !brk_r;
            end else if (ext_r && (rx_byte_s == SC_RIGHT)) begin
              right_key <= !brk_r;
            end else if (!ext_r && (rx_byte_s == SC_PAUSE)) begin
              if (brk_r) begin
                p_held_r <= 1'b0;
              end else begin
                if (!p_held_r) begin
                  pause <= ~pause;
                end
                p_held_r <= 1'b1;
              end
            end
            ext_r <= 1'b0;
            brk_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_car_keys.sv
// Self-checking bench for ps2_car_keys: table-driven PS/2 frames with a
// scoreboard of expected bytes/levels, plus timeout and mid-frame reset cases.
module tb_ps2_car_keys;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 3000;
  localparam int HALF           = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       left_key;
  logic       right_key;
  logic       pause;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       frame_err;

  ps2_car_keys #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .left_key  (left_key),
    .right_key (right_key),
    .pause     (pause),
    .scan_valid(scan_valid),
    .scan_code (scan_code),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       l;
    logic       r;
    logic       p;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    logic       bad;
    logic       l;
    logic       r;
    logic       p;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         err_count = 0;
  int         exp_err = 0;
  logic [7:0] exp_code = 8'h00;
  exp_t       sb_q[$];
  exp_t       mon_e;
  vec_t       vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard: every accepted byte must match the oldest expected entry, levels included
  always @(negedge clk) begin
    if (!reset && frame_err) err_count++;
    if (!reset && scan_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_scan actual=%0h required=none", scan_code);
      end else begin
        mon_e = sb_q.pop_front();
        chk("scan_code", {24'h0, scan_code}, {24'h0, mon_e.code});
        chk("left_at_valid", {31'h0, left_key}, {31'h0, mon_e.l});
        chk("right_at_valid", {31'h0, right_key}, {31'h0, mon_e.r});
        chk("pause_at_valid", {31'h0, pause}, {31'h0, mon_e.p});
      end
    end
  end

  function automatic logic [10:0] frame(input logic [7:0] b, input logic bad);
    return {1'b1, (~^b) ^ bad, b, 1'b0};
  endfunction

  task automatic ps2_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF / 2) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (HALF / 2) @(posedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic check_levels(input string tag, input logic l, input logic r, input logic p);
    chk({tag, "_left"}, {31'h0, left_key}, {31'h0, l});
    chk({tag, "_right"}, {31'h0, right_key}, {31'h0, r});
    chk({tag, "_pause"}, {31'h0, pause}, {31'h0, p});
  endtask

  task automatic send(input logic [7:0] b, input logic bad, input logic l, input logic r,
                      input logic p);
    if (!bad) begin
      sb_q.push_back({b, l, r, p});
      exp_code = b;
    end else begin
      exp_err++;
    end
    ps2_bits(frame(b, bad), 11);
    repeat (60) @(posedge clk);
    @(negedge clk);
    check_levels("step", l, r, p);
    chk("err_count", err_count, exp_err);
    chk("scan_code_held", {24'h0, scan_code}, {24'h0, exp_code});
    chk("scan_drained", sb_q.size(), 0);
  endtask

  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      send(vecs[i].b, vecs[i].bad, vecs[i].l, vecs[i].r, vecs[i].p);
    end
  endtask

  initial begin
    vecs[0]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h6B, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{8'h6B, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'h4D, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{8'h4D, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{8'h4D, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{8'h4D, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{8'h4D, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{8'h74, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{8'h74, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{8'hE0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{8'h6B, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{8'h6B, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{8'hE0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{8'h6B, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[19] = '{8'hE0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{8'h74, 1'b0, 1'b0, 1'b1, 1'b0};

    repeat (5) @(posedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_levels("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_scan_valid", {31'h0, scan_valid}, 32'h0);
    chk("reset_scan_code", {24'h0, scan_code}, 32'h0);
    chk("reset_frame_err", {31'h0, frame_err}, 32'h0);

    // left press/release, pause toggle with typematic repeats, bad parity, corrupted prefix
    run_vectors(0, 16);

    // abandon a frame after 5 bits and let the timeout expire
    ps2_bits(frame(8'h6B, 1'b0), 5);
    exp_err++;
    repeat (TIMEOUT_CYCLES + 100) @(posedge clk);
    @(negedge clk);
    chk("timeout_err", err_count, exp_err);
    check_levels("timeout", 1'b0, 1'b1, 1'b0);
    run_vectors(17, 18);

    // reset in the middle of E0 74 while both arrows are held
    send(8'hE0, 1'b0, 1'b1, 1'b1, 1'b0);
    ps2_bits(frame(8'h74, 1'b0), 4);
    @(posedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_code = 8'h00;
    check_levels("midreset", 1'b0, 1'b0, 1'b0);
    chk("midreset_scan_code", {24'h0, scan_code}, 32'h0);
    chk("midreset_frame_err", {31'h0, frame_err}, 32'h0);
    run_vectors(19, 20);

    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("final_queue_empty", sb_q.size(), 0);
    chk("final_err_count", err_count, exp_err);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_car_keys.md
# ps2_car_keys

Converts a PS/2 keyboard serial stream into the held-level steering controls and the pause toggle consumed by the car sprite/movement stage. Sits directly upstream of the car block: its `left_key`, `right_key` and `pause` outputs drive that block's inputs of the same names. The block receives and validates PS/2 frames, tracks the `E0`/`F0` prefix bytes, and keeps key state until the matching break code arrives.

## Interface
- `FILTER_LEN`, default 8: consecutive equal samples required before the filtered `ps2_clk` level changes.
- `TIMEOUT_CYCLES`, default 100000: idle `clk` cycles allowed mid-frame (1 ms at 100 MHz) before the frame is abandoned.
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  synchronous, active-high.
- `ps2_clk`  in  1  raw keyboard clock, asynchronous.
- `ps2_data`  in  1  raw keyboard data, asynchronous.
- `left_key`  out  1  high while the left arrow (`E0 6B`) is held.
- `right_key`  out  1  high while the right arrow (`E0 74`) is held.
- `pause`  out  1  toggles on each fresh press of P (`4D`).
- `scan_valid`  out  1  one-cycle pulse per accepted byte.
- `scan_code`  out  8  last accepted byte; valid while `scan_valid` is high and held afterwards.
- `frame_err`  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- Reset values: all outputs 0; receiver in IDLE; `ext`, `brk` and `p_held` cleared.
- Input conditioning:
  - `ps2_clk` and `ps2_data` each pass through a 3-flop synchronizer.
  - The clock then passes through the `FILTER_LEN` glitch filter.
  - A filtered 1→0 transition is a falling edge. Data is sampled in that cycle.
- Receiver FSM states are IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with data 0 (start bit), go to DATA and set `bitcnt` to 0. A start bit of 1 is ignored and the FSM stays in IDLE with no error.
  - DATA: shift bits in LSB first. After the 8th bit, go to PARITY.
  - PARITY: store the bit and go to STOP.
  - STOP: if the stop bit is 1 and data plus parity have an odd number of ones, accept the byte. Otherwise pulse `frame_err`. Both cases return to IDLE.
  - Timeout: in any state other than IDLE, `TIMEOUT_CYCLES` cycles without an edge pulses `frame_err` and returns to IDLE. The counter clears on every edge.
- Decoder, applied to each accepted byte:
  - `E0`: set `ext`.
  - `F0`: set `brk`.
  - Any other byte is a key event. After the event, `ext` and `brk` both clear.
  - `ext` with `6B`: `left_key` ← !`brk`.
  - `ext` with `74`: `right_key` ← !`brk`.
  - Non-ext `4D` make: if !`p_held`, toggle `pause`; then set `p_held`. Typematic repeats of the make code do not toggle `pause`.
  - Non-ext `4D` break: clear `p_held`.
  - All other codes, including the `E1` Pause-key sequence, change no state other than `scan_code`.
- Any `frame_err` also clears `ext` and `brk`, so a corrupted prefix never attaches to the next byte. Key levels are not cleared.
- Both arrows held: `left_key` and `right_key` are both 1. Arbitration is left to the car stage.

## Timing
- The filtered edge lags the raw `ps2_clk` edge by 3 + `FILTER_LEN` cycles. Data takes the same synchronizer path and is sampled in the edge-detect cycle.
- If the stop bit is accepted in cycle N:
  - `scan_valid` and `scan_code` are valid in cycle N+1.
  - `left_key`, `right_key` and `pause` take their new values in cycle N+1.
- `frame_err` is high in the cycle after the failing stop edge or the expired timeout.
- Reset mid-frame discards the partial byte. The next falling edge is treated as a start-bit candidate.
- Outputs are stable between accepted bytes, so the car stage may sample them on its `refresh_tick` without a handshake.

## Structure
- Shared package/header holds the scancode constants:
  - `SC_EXT` = E0, `SC_BREAK` = F0
  - `SC_LEFT` = 6B, `SC_RIGHT` = 74
  - `SC_PAUSE` = 4D
- Sub-module `ps2_rx` contains the synchronizers, filter, edge detect, receiver FSM and timeout. It outputs `rx_valid`, `rx_byte` and `rx_err`.
- The top level holds the prefix/decoder registers and output flops.

## Test plan
- Send `E0 6B` → `left_key` = 1 in the cycle after the stop bit. Then send `E0 F0 6B` → `left_key` = 0. `right_key` stays 0 throughout.
- Send `4D 4D 4D F0 4D 4D` → `pause` goes 0→1 on the first byte. The two repeats do not change it. The break releases `p_held`, and the last `4D` takes `pause` to 0.
- Send byte `74` with a bad parity bit → one `frame_err` pulse, no `scan_valid`, `right_key` stays 0. Then send a clean `E0 74` → `right_key` = 1.
- Send 5 bits of a frame, then hold `ps2_clk` high for `TIMEOUT_CYCLES` cycles → `frame_err` pulses once. A following clean `E0 6B` decodes correctly.
- Send `E0`, then a corrupted frame, then `6B` → no change to `left_key`, because the error cleared `ext`.
- Assert `reset` during bit 4 of `E0 74` while `left_key` = 1 → all outputs are 0 after reset. A following clean `E0 74` sets `right_key` = 1.
